// File: rtl/nand_seq_pkg.sv
// Shared constants for the NAND-only sequencer: op codes, FSM encodings
// and the per-op step-count table.
package nand_seq_pkg;

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [2:0] n_steps(input logic [2:0] op);
    logic [2:0] n;
    case (op)
      OP_AND:          n = 3'd2;
      OP_OR:           n = 3'd3;
      OP_NOR, OP_XOR:  n = 3'd4;
      OP_XNOR:         n = 3'd5;
      default:         n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/nand_gate.sv
// Single-bit two-input NAND cell.
module nand_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a & b);

endmodule

// File: rtl/nand_sequencer_nand_vec.sv
// W-bit NAND unit built from W single-bit nand_gate cells.
module nand_vec #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    nand_gate u_gate (
      .a (a[i]),
      .b (b[i]),
      .y (y[i])
    );
  end

endmodule

// File: rtl/nand_sequencer.sv
// Multi-cycle logic unit: every function is evaluated as a sequence of
// NANDs through one shared W-bit NAND unit, one evaluation per clock.
module nand_sequencer
  import nand_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y
);

  logic [1:0]   state;
  logic [2:0]   step;
  logic [2:0]   op_r;
  logic [W-1:0] a_r, b_r;
  logic [W-1:0] t_r, u_r, v_r, y_r;
  logic [W-1:0] nx, ny, nand_out;
  logic         last, wr_t, wr_u, wr_v;

  nand_vec #(.W(W)) u_nand (
    .a (nx),
    .b (ny),
    .y (nand_out)
  );

  // Operand routing into the shared NAND for the current (op, step).
  always_comb begin
    nx = a_r;
    ny = b_r;
    case (op_r)
      OP_NOT: ny = a_r;
      OP_AND: if (step == 3'd1) begin nx = t_r; ny = t_r; end
      OP_OR, OP_NOR: begin
        case (step)
          3'd0:    begin nx = a_r; ny = a_r; end
          3'd1:    begin nx = b_r; ny = b_r; end
          3'd2:    begin nx = t_r; ny = u_r; end
          default: begin nx = t_r; ny = t_r; end
        endcase
      end
      OP_XOR, OP_XNOR: begin
        case (step)
          3'd0:    begin nx = a_r; ny = b_r; end
          3'd1:    begin nx = a_r; ny = t_r; end
          3'd2:    begin nx = b_r; ny = t_r; end
          3'd3:    begin nx = u_r; ny = v_r; end
          default: begin nx = t_r; ny = t_r; end
        endcase
      end
      default: ;
    endcase
  end

  // Intermediate results for the inverting tail of NOR/XNOR are parked in t.
  always_comb begin
    last = (step == (n_steps(op_r) - 3'd1));
    wr_t = (step == 3'd0) || (op_r == OP_NOR && step == 3'd2) ||
           (op_r == OP_XNOR && step == 3'd3);
    wr_u = (step == 3'd1) && (op_r == OP_OR || op_r == OP_NOR ||
                              op_r == OP_XOR || op_r == OP_XNOR);
    wr_v = (step == 3'd2) && (op_r == OP_XOR || op_r == OP_XNOR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      step  <= 3'd0;
      t_r   <= '0;
      u_r   <= '0;
      v_r   <= '0;
      y_r   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            step  <= 3'd0;
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (last) begin
            y_r   <= (op_r == OP_RSV) ? '0 : nand_out;
            state <= ST_DONE;
          end else begin
            if (wr_t) t_r <= nand_out;
            if (wr_u) u_r <= nand_out;
            if (wr_v) v_r <= nand_out;
            step <= step + 3'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign y         = y_r;

endmodule

// File: tb/tb_nand_sequencer.sv
// Self-checking bench for nand_sequencer: vector table, directed corner
// sequences and randomized ops against a boolean reference model.
module tb_nand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;

  int checks   = 0;
  int failures = 0;

  nand_sequencer #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    int         n;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_y(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return ~(x & z);
      3'd1: return ~x;
      3'd2: return x & z;
      3'd3: return x | z;
      3'd4: return ~(x | z);
      3'd5: return x ^ z;
      3'd6: return ~(x ^ z);
      default: return 8'h00;
    endcase
  endfunction

  function automatic int ref_n(input logic [2:0] o);
    int steps [8] = '{1, 1, 2, 3, 4, 4, 5, 1};
    return steps[o];
  endfunction

  // One full transaction; returns the result and accept-to-out_valid edge count.
  task automatic do_op(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       input bit mangle, input int hold,
                       output logic [7:0] ry, output int lat);
    int cnt;
    @(negedge clk);
    chk("ready_before_accept", in_ready, 1);
    in_valid = 1'b1; op = o; a = aa; b = bb; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (mangle) begin a = 8'h00; op = 3'b000; end
    chk("busy_after_accept", in_ready, 0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); cnt++;
      @(negedge clk);
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
      lat = -1; ry = 'x;
      return;
    end
    ry = y; lat = cnt;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_y", y, ry);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [7:0] ry;
    logic [2:0] ro;
    logic [7:0] ra, rb;
    int lat, cyc, nacc;
    int acc [3];

    tbl[0] = '{3'd0, 8'hF0, 8'hCC, 8'h3F, 1};
    tbl[1] = '{3'd1, 8'hF0, 8'hCC, 8'h0F, 1};
    tbl[2] = '{3'd2, 8'hF0, 8'hCC, 8'hC0, 2};
    tbl[3] = '{3'd3, 8'hF0, 8'hCC, 8'hFC, 3};
    tbl[4] = '{3'd4, 8'hF0, 8'hCC, 8'h03, 4};
    tbl[5] = '{3'd5, 8'hF0, 8'hCC, 8'h3C, 4};
    tbl[6] = '{3'd6, 8'hF0, 8'hCC, 8'hC3, 5};
    tbl[7] = '{3'd7, 8'hF0, 8'hCC, 8'h00, 1};

    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_y", y, 8'h00);

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 0, ry, lat);
      chk($sformatf("tbl_y_op%0d", i), ry, tbl[i].y);
      chk($sformatf("tbl_lat_op%0d", i), lat, tbl[i].n);
    end

    // Backpressure on XOR for 10 cycles.
    do_op(3'd5, 8'hF0, 8'hCC, 1'b0, 10, ry, lat);
    chk("bp_y", ry, 8'h3C);

    // Operand/op changes after accept must be ignored.
    do_op(3'd5, 8'hF0, 8'hCC, 1'b1, 0, ry, lat);
    chk("stable_y", ry, 8'h3C);
    chk("stable_lat", lat, 4);

    // Back-to-back AND with in_valid and out_ready held high.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd2; a = 8'hF0; b = 8'hCC; out_ready = 1'b1;
    cyc = 0; nacc = 0;
    while (nacc < 3 && cyc < 40) begin
      if (in_ready) begin acc[nacc] = cyc; nacc++; end
      if (out_valid) chk("b2b_y", y, 8'hC0);
      if (nacc < 3) begin @(posedge clk); @(negedge clk); cyc++; end
    end
    chk("b2b_accepts", nacc, 3);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    if (nacc == 3) begin
      chk("b2b_gap1", acc[1] - acc[0], 4);
      chk("b2b_gap2", acc[2] - acc[1], 4);
    end
    cyc = 0;
    while (!in_ready && cyc < 20) begin @(posedge clk); @(negedge clk); cyc++; end
    out_ready = 1'b0;
    chk("b2b_drain", in_ready, 1);

    // Reset during step 2 of XNOR.
    in_valid = 1'b1; op = 3'd6; a = 8'hF0; b = 8'hCC;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_y", y, 8'h00);
    chk("rst_mid_in_ready", in_ready, 1);
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) cyc++;
    end
    chk("rst_mid_no_result", cyc, 0);
    do_op(3'd0, 8'hF0, 8'hCC, 1'b0, 0, ry, lat);
    chk("post_rst_nand", ry, 8'h3F);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(ro, ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), ry, lat);
      chk($sformatf("rand_y_op%0d", ro), ry, ref_y(ro, ra, rb));
      chk($sformatf("rand_lat_op%0d", ro), lat, ref_n(ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
